// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared encodings and op-decode helpers for the iterative divider
package div_unit_pkg;

   localparam int DIV_DATA_W   = 32;
   localparam int DIV_CNT_W    = 5;
   localparam int DIV_OP_WIDTH = 2;

   // funct3[1:0] of the RV32M divide group
   localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'b10;
   localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_ST_IDLE = 2'd0,
      DIV_ST_CALC = 2'd1,
      DIV_ST_DONE = 2'd2
   } div_state_e;

   function automatic logic div_op_signed(input logic [DIV_OP_WIDTH-1:0] op);
      return ~op[0];
   endfunction

   function automatic logic div_op_rem(input logic [DIV_OP_WIDTH-1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift, compare, conditional subtract
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_i,
   input  logic [DATA_W-1:0] dvd_i,
   input  logic [DATA_W-1:0] dvs_i,
   output logic [DATA_W-1:0] rem_o,
   output logic [DATA_W-1:0] dvd_o,
   output logic              qbit_o
);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W:0]   diff;

   assign shifted = {rem_i[DATA_W-2:0], dvd_i[DATA_W-1]};
   assign diff    = {1'b0, shifted} - {1'b0, dvs_i};

   // A set remainder MSB means the shifted value exceeds DATA_W bits, so it is always >= divisor
   assign qbit_o  = rem_i[DATA_W-1] | ~diff[DATA_W];
   assign rem_o   = qbit_o ? diff[DATA_W-1:0] : shifted;
   assign dvd_o   = {dvd_i[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M divider with start/busy/valid handshake
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W,
   parameter int CNT_W  = DIV_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              kill_i,
   input  logic [1:0]        div_op_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic              busy_o,
   output logic              result_valid_o,
   output logic [DATA_W-1:0] result_o
);

   localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W-1);

   div_state_e        state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] dvd_q, dvd_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;

   logic              in_signed, in_rem, a_neg, b_neg, div_zero, overflow;
   logic [DATA_W-1:0] a_mag, b_mag, special_res;
   logic [DATA_W-1:0] step_rem, step_dvd, final_quo, calc_res;
   logic              step_qbit;

   assign in_signed = div_op_signed(div_op_i);
   assign in_rem    = div_op_rem(div_op_i);
   assign a_neg     = in_signed & dividend_i[DATA_W-1];
   assign b_neg     = in_signed & divisor_i[DATA_W-1];
   assign a_mag     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
   assign b_mag     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
   assign div_zero  = (divisor_i == '0);
   assign overflow  = in_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);

   // Divide-by-zero takes priority; it also covers a signed overflow dividend with zero divisor
   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = in_rem ? dividend_i : '1;
      end else begin
         special_res = in_rem ? '0 : MIN_NEG;
      end
   end

   div_step #(
      .DATA_W (DATA_W)
   ) u_div_step (
      .rem_i  (rem_q),
      .dvd_i  (dvd_q),
      .dvs_i  (dvs_q),
      .rem_o  (step_rem),
      .dvd_o  (step_dvd),
      .qbit_o (step_qbit)
   );

   assign final_quo = {quo_q[DATA_W-2:0], step_qbit};

   always_comb begin
      calc_res = '0;
      if (div_op_rem(op_q)) begin
         calc_res = rneg_q ? (~step_rem + 1'b1) : step_rem;
      end else begin
         calc_res = qneg_q ? (~final_quo + 1'b1) : final_quo;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      unique case (state_q)
         DIV_ST_IDLE: begin
            if (start_i && !kill_i) begin
               op_d   = div_op_i;
               dvd_d  = a_mag;
               dvs_d  = b_mag;
               rem_d  = '0;
               quo_d  = '0;
               cnt_d  = '0;
               qneg_d = a_neg ^ b_neg;
               rneg_d = a_neg;
               if (div_zero || overflow) begin
                  state_d  = DIV_ST_DONE;
                  result_d = special_res;
               end else begin
                  state_d  = DIV_ST_CALC;
               end
            end
         end
         DIV_ST_CALC: begin
            if (kill_i) begin
               state_d = DIV_ST_IDLE;
            end else begin
               rem_d = step_rem;
               dvd_d = step_dvd;
               quo_d = final_quo;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d  = DIV_ST_DONE;
                  result_d = calc_res;
               end
            end
         end
         DIV_ST_DONE: begin
            state_d = DIV_ST_IDLE;
         end
         default: begin
            state_d = DIV_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DIV_ST_IDLE;
         op_q     <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
      end
   end

   // A kill landing in DONE suppresses the pulse so a flushed op never reports a result
   assign busy_o         = (state_q == DIV_ST_CALC);
   assign result_valid_o = (state_q == DIV_ST_DONE) && !kill_i;
   assign result_o       = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized scoreboard bench for div_unit against an arithmetic reference
module tb_div_unit;
   import div_unit_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        kill_i;
   logic [1:0]  div_op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic        busy_o;
   logic        result_valid_o;
   logic [31:0] result_o;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [31:0] last_res = '0;

   div_unit #(.DATA_W(32), .CNT_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .kill_i         (kill_i),
      .div_op_i       (div_op_i),
      .dividend_i     (dividend_i),
      .divisor_i      (divisor_i),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic        sgn;
      logic [31:0] qv, rv;
      sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
      if (b == 32'd0) begin
         qv = 32'hFFFF_FFFF;
         rv = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         qv = 32'h8000_0000;
         rv = 32'd0;
      end else if (sgn) begin
         qv = $signed(a) / $signed(b);
         rv = $signed(a) % $signed(b);
      end else begin
         qv = a / b;
         rv = a % b;
      end
      return (op == DIV_OP_REM || op == DIV_OP_REMU) ? rv : qv;
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
      if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'($urandom_range(0, 20));
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation, value and cycle
   always @(negedge clk) begin
      if (!rst && result_valid_o) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=%h expected=none", result_o);
         end else begin
            mon_e = sb_q.pop_front();
            check("result", result_o, mon_e.res);
            check("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int t);
      exp_t e;
      @(negedge clk);
      div_op_i   = op;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      @(posedge clk);
      #1;
      start_i    = 1'b0;
      t          = cyc;
      if (push) begin
         e.res = ref_div(op, a, b);
         e.cyc = t + ref_lat(op, a, b) - 1;
         sb_q.push_back(e);
         last_res = e.res;
      end
      dividend_i = $urandom;
      divisor_i  = $urandom;
      div_op_i   = 2'($urandom);
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
      int t, lat, busy_cnt;
      lat      = ref_lat(op, a, b);
      busy_cnt = 0;
      accept(op, a, b, 1'b1, t);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         if (busy_o) busy_cnt++;
         start_i = (hold && k < lat - 1) ? 1'b1 : 1'b0;
      end
      #1;
      check("busy_cycles", 32'(busy_cnt), 32'(lat - 1));
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL missing_valid actual=%0d pending expected=0", sb_q.size());
         sb_q.delete();
      end
      @(posedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int t;
      rst = 1'b1; start_i = 1'b0; kill_i = 1'b0;
      div_op_i = '0; dividend_i = '0; divisor_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_valid", 32'(result_valid_o), 32'd0);
      check("reset_result", result_o, 32'd0);
      rst = 1'b0;

      run(DIV_OP_DIVU, 32'd100, 32'd7, 1'b0);
      run(DIV_OP_REMU, 32'd100, 32'd7, 1'b0);
      run(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run(DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
      run(DIV_OP_DIVU, 32'd5, 32'd0, 1'b0);
      run(DIV_OP_REMU, 32'd5, 32'd0, 1'b0);
      run(DIV_OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
      run(DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 1'b0);
      run(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
      run(DIV_OP_DIVU, 32'd1000, 32'd10, 1'b1);

      // Kill at accept+10; the follow-up op is accepted on the very next edge
      accept(DIV_OP_DIVU, 32'd100, 32'd7, 1'b0, t);
      repeat (10) @(negedge clk);
      kill_i = 1'b1;
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      check("kill_busy", 32'(busy_o), 32'd0);
      check("kill_valid", 32'(result_valid_o), 32'd0);
      check("kill_result_hold", result_o, last_res);
      run(DIV_OP_DIVU, 32'd9, 32'd3, 1'b0);

      // Synchronous reset mid-operation
      accept(DIV_OP_DIVU, 32'd100, 32'd7, 1'b0, t);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_busy", 32'(busy_o), 32'd0);
      check("midreset_valid", 32'(result_valid_o), 32'd0);
      check("midreset_result", result_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // start and kill together in IDLE: a divide-by-zero would pulse at once if accepted
      @(negedge clk);
      div_op_i = DIV_OP_DIVU; dividend_i = 32'd5; divisor_i = 32'd0;
      start_i = 1'b1; kill_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0; kill_i = 1'b0;
      @(negedge clk);
      check("startkill_busy", 32'(busy_o), 32'd0);
      check("startkill_valid", 32'(result_valid_o), 32'd0);

      for (int i = 0; i < 40; i++) begin
         run(2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
